// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared state encoding and default widths for pipeline stage registers
package pipe_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int CTRL_W_DEF = 4;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } pipe_state_t;

endpackage

// File: rtl/pipe_stall_counter.sv
// rtl/pipe_stall_counter.sv - saturating counter of backpressure cycles
module pipe_stall_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (inc && (cnt != {CNT_W{1'b1}})) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/pipe_stage_reg.sv
// rtl/pipe_stage_reg.sv - valid/ready pipeline stage register with optional two-entry skid buffer
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int CTRL_W = CTRL_W_DEF,
    parameter int SKID   = 1,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  stall_cnt
);

    logic              out_valid_q;
    logic [CTRL_W-1:0] ctrl_q;
    logic [DATA_W-1:0] data_q;
    logic              xfer_in;
    logic              xfer_out;

    assign xfer_in   = in_valid & in_ready;
    assign xfer_out  = out_valid_q & out_ready;
    assign out_valid = out_valid_q;
    // A bubble must never carry live control bits downstream
    assign out_ctrl  = out_valid_q ? ctrl_q : '0;
    assign out_data  = data_q;

    generate
        if (SKID != 0) begin : g_skid
            pipe_state_t       state_q;
            pipe_state_t       state_d;
            logic [CTRL_W-1:0] skid_ctrl_q;
            logic [DATA_W-1:0] skid_data_q;
            logic              load_main;
            logic              load_skid;
            logic              move_skid;

            assign in_ready    = (state_q != TWO);
            assign out_valid_q = (state_q != EMPTY);

            always_comb begin
                state_d   = state_q;
                load_main = 1'b0;
                load_skid = 1'b0;
                move_skid = 1'b0;
                if (flush) begin
                    state_d = EMPTY;
                end else begin
                    case (state_q)
                        EMPTY: begin
                            if (xfer_in) begin
                                state_d   = ONE;
                                load_main = 1'b1;
                            end
                        end
                        ONE: begin
                            if (xfer_in && !xfer_out) begin
                                state_d   = TWO;
                                load_skid = 1'b1;
                            end else if (xfer_out && !xfer_in) begin
                                state_d   = EMPTY;
                            end else if (xfer_in && xfer_out) begin
                                load_main = 1'b1;
                            end
                        end
                        TWO: begin
                            if (xfer_out) begin
                                state_d   = ONE;
                                move_skid = 1'b1;
                            end
                        end
                        default: state_d = EMPTY;
                    endcase
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    state_q     <= EMPTY;
                    ctrl_q      <= '0;
                    data_q      <= '0;
                    skid_ctrl_q <= '0;
                    skid_data_q <= '0;
                end else begin
                    state_q <= state_d;
                    if (load_main) begin
                        ctrl_q <= in_ctrl;
                        data_q <= in_data;
                    end else if (move_skid) begin
                        ctrl_q <= skid_ctrl_q;
                        data_q <= skid_data_q;
                    end
                    if (load_skid) begin
                        skid_ctrl_q <= in_ctrl;
                        skid_data_q <= in_data;
                    end
                end
            end
        end else begin : g_reg
            assign in_ready = !out_valid_q | out_ready;

            always_ff @(posedge clk) begin
                if (rst) begin
                    out_valid_q <= 1'b0;
                    ctrl_q      <= '0;
                    data_q      <= '0;
                end else if (flush) begin
                    out_valid_q <= 1'b0;
                end else if (xfer_in) begin
                    out_valid_q <= 1'b1;
                    ctrl_q      <= in_ctrl;
                    data_q      <= in_data;
                end else if (xfer_out) begin
                    out_valid_q <= 1'b0;
                end
            end
        end
    endgenerate

    pipe_stall_counter #(
        .CNT_W(CNT_W)
    ) u_stall_counter (
        .clk(clk),
        .rst(rst),
        .inc(out_valid_q & ~out_ready),
        .cnt(stall_cnt)
    );

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb/tb_pipe_stage_reg.sv - scoreboard bench for pipe_stage_reg, skid and plain variants
module tb_pipe_stage_reg;

    localparam int CNT_MAX = 15;

    typedef struct packed {
        logic [3:0]  c;
        logic [31:0] d;
    } ent_t;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic [3:0]  in_ctrl;
    logic [31:0] in_data;
    logic        out_ready;

    logic        s_in_ready, s_out_valid;
    logic [3:0]  s_out_ctrl, s_stall;
    logic [31:0] s_out_data;
    logic        n_in_ready, n_out_valid;
    logic [3:0]  n_out_ctrl, n_stall;
    logic [31:0] n_out_data;

    int   n_vec;
    int   n_miss;
    bit   checking;
    ent_t q_s[$];
    ent_t q_n[$];
    int   cnt_s;
    int   cnt_n;

    pipe_stage_reg #(.DATA_W(32), .CTRL_W(4), .SKID(1), .CNT_W(4)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(s_in_ready), .in_ctrl(in_ctrl), .in_data(in_data),
        .out_valid(s_out_valid), .out_ready(out_ready), .out_ctrl(s_out_ctrl),
        .out_data(s_out_data), .stall_cnt(s_stall)
    );

    pipe_stage_reg #(.DATA_W(32), .CTRL_W(4), .SKID(0), .CNT_W(4)) dut0 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(n_in_ready), .in_ctrl(in_ctrl), .in_data(in_data),
        .out_valid(n_out_valid), .out_ready(out_ready), .out_ctrl(n_out_ctrl),
        .out_data(n_out_data), .stall_cnt(n_stall)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference: a FIFO of capacity 2 (skid) or 1 (plain), updated at each edge
    initial begin
        bit rdy_s, rdy_n, vld_s, vld_n;
        cnt_s = 0;
        cnt_n = 0;
        forever begin
            @(posedge clk);
            rdy_s = (q_s.size() < 2);
            rdy_n = (q_n.size() == 0) || out_ready;
            vld_s = (q_s.size() > 0);
            vld_n = (q_n.size() > 0);
            if (rst) begin
                q_s.delete();
                q_n.delete();
                cnt_s = 0;
                cnt_n = 0;
            end else begin
                if (vld_s && !out_ready && cnt_s < CNT_MAX) cnt_s++;
                if (vld_n && !out_ready && cnt_n < CNT_MAX) cnt_n++;
                if (flush) begin
                    q_s.delete();
                    q_n.delete();
                end else begin
                    if (vld_s && out_ready) void'(q_s.pop_front());
                    if (vld_n && out_ready) void'(q_n.pop_front());
                    if (in_valid && rdy_s) q_s.push_back({in_ctrl, in_data});
                    if (in_valid && rdy_n) q_n.push_back({in_ctrl, in_data});
                end
            end
        end
    end

    // Monitor: compares both instances against the reference between edges
    always @(negedge clk) begin
        if (checking) begin
            chk("s_out_valid", s_out_valid, q_s.size() > 0);
            chk("s_in_ready", s_in_ready, q_s.size() < 2);
            chk("s_stall_cnt", s_stall, cnt_s);
            if (q_s.size() > 0) begin
                chk("s_out_ctrl", s_out_ctrl, q_s[0].c);
                chk("s_out_data", s_out_data, q_s[0].d);
            end else begin
                chk("s_bubble_ctrl", s_out_ctrl, 0);
            end
            chk("n_out_valid", n_out_valid, q_n.size() > 0);
            chk("n_in_ready", n_in_ready, (q_n.size() == 0) || out_ready);
            chk("n_stall_cnt", n_stall, cnt_n);
            if (q_n.size() > 0) begin
                chk("n_out_ctrl", n_out_ctrl, q_n[0].c);
                chk("n_out_data", n_out_data, q_n[0].d);
            end else begin
                chk("n_bubble_ctrl", n_out_ctrl, 0);
            end
        end
    end

    task automatic drive(input logic v, input logic [3:0] c, input logic [31:0] d,
                         input logic ordy, input logic fl, input logic r);
        in_valid  = v;
        in_ctrl   = c;
        in_data   = d;
        out_ready = ordy;
        flush     = fl;
        rst       = r;
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_vec    = 0;
        n_miss   = 0;
        checking = 1'b0;

        drive(0, 4'h0, 0, 0, 0, 1);
        drive(0, 4'h0, 0, 0, 0, 1);
        checking = 1'b1;
        chk("rst_out_valid", s_out_valid, 0);
        chk("rst_out_data", s_out_data, 0);
        chk("rst_out_ctrl", s_out_ctrl, 0);
        chk("rst_stall", s_stall, 0);
        chk("rst_in_ready", s_in_ready, 1);
        chk("rst0_out_data", n_out_data, 0);

        // Streaming
        for (int i = 1; i <= 8; i++) begin
            drive(1, 4'(i), 32'(i), 1, 0, 0);
            chk("stream_data", s_out_data, i);
            chk("stream_ready", s_in_ready, 1);
            chk("stream0_data", n_out_data, i);
        end
        drive(0, 4'h0, 0, 1, 0, 0);
        chk("stream_stall", s_stall, 0);
        chk("stream_empty", s_out_valid, 0);

        // Backpressure
        drive(1, 4'h1, 32'hA, 0, 0, 0);
        drive(1, 4'h2, 32'hB, 0, 0, 0);
        chk("bp_in_ready", s_in_ready, 0);
        drive(0, 4'h0, 0, 0, 0, 0);
        chk("bp_stall", s_stall, 2);
        chk("bp_head", s_out_data, 32'hA);
        drive(0, 4'h0, 0, 1, 0, 0);
        chk("bp_second", s_out_data, 32'hB);
        drive(0, 4'h0, 0, 1, 0, 0);
        chk("bp_drained", s_out_valid, 0);

        // Flush with a simultaneous input
        drive(1, 4'hF, 32'hC, 0, 0, 0);
        chk("fl_ctrl_held", s_out_ctrl, 4'hF);
        drive(1, 4'hF, 32'hD, 0, 1, 0);
        chk("fl_valid", s_out_valid, 0);
        chk("fl_ctrl", s_out_ctrl, 0);
        for (int i = 0; i < 3; i++) begin
            drive(0, 4'hF, 0, 1, 0, 0);
            chk("fl_no_d", s_out_valid, 0);
            chk("bubble_ctrl", s_out_ctrl, 0);
        end

        // Saturation
        drive(1, 4'h3, 32'h55, 0, 0, 0);
        for (int i = 0; i < 20; i++) drive(0, 4'h0, 0, 0, 0, 0);
        chk("sat_stall", s_stall, 15);
        chk("sat0_stall", n_stall, 15);

        // Reset while holding two entries
        drive(1, 4'h1, 32'h1, 0, 0, 0);
        chk("pre_rst_two", s_in_ready, 0);
        drive(1, 4'h7, 32'h77, 0, 0, 1);
        chk("mid_rst_valid", s_out_valid, 0);
        chk("mid_rst_data", s_out_data, 0);
        chk("mid_rst_stall", s_stall, 0);
        chk("mid_rst_ready", s_in_ready, 1);
        chk("mid_rst0_ready", n_in_ready, 1);

        // Randomized traffic
        for (int i = 0; i < 1500; i++) begin
            drive($urandom_range(0, 3) != 0, 4'($urandom), $urandom,
                  $urandom_range(0, 2) != 0, $urandom_range(0, 31) == 0,
                  $urandom_range(0, 99) == 0);
        end
        drive(0, 4'h0, 0, 1, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/pipe_stage_reg.md
PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 Parameter DATA_W, default 32, width of the datapath payload (instr, npc, rd, operands, ALU result packed by the instantiating stage).
REQ-002 Parameter CTRL_W, default 4, width of the control-signal vector (e.g. RegWrite, MemToReg, MemRead, MemWrite).
REQ-003 Parameter SKID, default 1: 1 selects the two-entry skid buffer; 0 selects a single register with combinational ready.
REQ-004 Parameter CNT_W, default 16, width of the stall counter.
REQ-005 clk  input  1  the single clock; all state updates on its rising edge.
REQ-006 rst  input  1  reset, synchronous and active-high.
REQ-007 flush  input  1  kill all held entries this cycle (branch/jump redirect).
REQ-008 in_valid  input  1  upstream stage presents a valid entry.
REQ-009 in_ready  output  1  this stage accepts the entry this cycle.
REQ-010 in_ctrl  input  CTRL_W  upstream control vector.
REQ-011 in_data  input  DATA_W  upstream payload.
REQ-012 out_valid  output  1  the held entry is valid.
REQ-013 out_ready  input  1  downstream stage consumes the entry this cycle.
REQ-014 out_ctrl  output  CTRL_W  control vector; forced to 0 whenever out_valid=0 (bubble).
REQ-015 out_data  output  DATA_W  payload of the head entry; value unspecified when out_valid=0.
REQ-016 stall_cnt  output  CNT_W  saturating count of cycles with out_valid=1 and out_ready=0.

Function
REQ-017 Transfer in = in_valid & in_ready; transfer out = out_valid & out_ready; both evaluated at the same clock edge.
REQ-018 Latency is one cycle: data accepted at edge N appears on out_* after edge N when the stage was empty.
REQ-019 SKID=0: in_ready = !out_valid | out_ready; on a transfer in, the register loads in_ctrl/in_data; on a transfer out with no transfer in, out_valid clears.
REQ-020 SKID=1: state machine EMPTY (0 entries), ONE (main valid), TWO (main and skid valid); in_ready is registered and equals (state != TWO).
REQ-021 SKID=1 transitions: EMPTY+in -> ONE; ONE+in+!out -> TWO (input to skid); ONE+out+!in -> EMPTY; ONE+in+out -> ONE (input to main); TWO+out -> ONE (skid moves to main); otherwise hold.
REQ-022 Order is strictly FIFO; no entry is duplicated or dropped, except by flush.
REQ-023 flush=1: state -> EMPTY (all valids cleared) at that edge; a simultaneous transfer in is discarded; flush has priority over in_valid and out_ready.
REQ-024 out_ctrl = in the held head entry's control when out_valid=1, else all-zero, so a bubble never writes registers or memory.
REQ-025 stall_cnt increments by 1 on each cycle with out_valid & !out_ready, holds at 2^CNT_W-1, and is not cleared by flush.
REQ-026 Data registers load only on transfer in (no enable toggling on idle cycles).

Reset
REQ-027 rst=1 at a rising edge: state EMPTY, out_valid=0, out_ctrl=0, out_data=0, skid data=0, stall_cnt=0; in_ready=1 from the following cycle (SKID=1) or combinationally (SKID=0).
REQ-028 Reset mid-transfer discards all held and incoming entries; rst has priority over flush and handshakes.

Structure
REQ-029 A shared package pipe_pkg holds the state encoding (EMPTY=2'd0, ONE=2'd1, TWO=2'd2) and the default width constants DATA_W_DEF=32, CTRL_W_DEF=4.
REQ-030 One sub-module, pipe_stall_counter (saturating counter, parameter CNT_W), is instantiated; the skid logic stays in pipe_stage_reg under a generate on SKID.

Verification
REQ-031 Streaming: out_ready=1, in_valid=1 for 8 cycles with in_data=1..8 -> out_data=1..8 one cycle later, in_ready stays 1, stall_cnt=0.
REQ-032 Backpressure (SKID=1): load 0xA, 0xB with out_ready=0 -> state TWO, in_ready=0; raise out_ready -> 0xA then 0xB emitted in order, stall_cnt=2 after two stalled cycles.
REQ-033 Flush: stage holding 0xC (ctrl=4'b1111) with flush=1 and in_valid=1 (0xD) -> next cycle out_valid=0, out_ctrl=4'b0000, 0xD never appears.
REQ-034 Bubble masking: in_valid=0 with in_ctrl=4'b1111 -> out_ctrl=0 throughout.
REQ-035 Saturation: CNT_W=4, out_valid=1, out_ready=0 for 20 cycles -> stall_cnt stops at 15.
REQ-036 Reset mid-operation: rst=1 while state TWO -> next cycle out_valid=0, out_data=0, stall_cnt=0, in_ready=1; SKID=0 run of REQ-031 gives identical output sequence.
